// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
// Shared definitions for the push-button debouncer / count-enable generator.
//   estado_t     : 2-bit FSM state type
//   SOLTO        : button released, waiting for a press
//   FILTRA_ALTO  : press seen, counting consecutive high samples
//   PRESSIONADO  : press accepted, button held
//   FILTRA_BAIXO : release seen, counting consecutive low samples
// -----------------------------------------------------------------------------
package debouncer_pkg;

    typedef logic [1:0] estado_t;

    localparam estado_t SOLTO        = 2'd0;
    localparam estado_t FILTRA_ALTO  = 2'd1;
    localparam estado_t PRESSIONADO  = 2'd2;
    localparam estado_t FILTRA_BAIXO = 2'd3;

endpackage

// File: rtl/sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk   : destination clock
//   clear : asynchronous active-high reset, both flops cleared to 0
//   d     : asynchronous input level
//   q     : synchronized level, two clk edges after d settles
// -----------------------------------------------------------------------------
module sincronizador_2ff (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (r_sync gets the old r_meta).
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/debouncer_pulso_t.sv
// -----------------------------------------------------------------------------
// debouncer_pulso_t
// Debounces a raw push-button and produces a one-cycle count-enable pulse for
// the T input of a downstream synchronous counter.
//   Parameters
//     DEBOUNCE_CYCLES : consecutive synchronized samples needed to accept a
//                       level change (2..255)
//     REPEAT_CYCLES   : auto-repeat period while held (2..255)
//   Ports
//     clk     : clock, all state changes on the rising edge
//     clear   : asynchronous active-high reset
//     btn     : raw asynchronous button level, 1 = pressed
//     T       : registered one-cycle pulse per accepted press
//     estavel : debounced button level
//   Build option
//     DEBOUNCER_AUTO_REPEAT_EN : when defined, a held button emits an extra
//                                T pulse every REPEAT_CYCLES cycles after the
//                                initial one.
// -----------------------------------------------------------------------------
module debouncer_pulso_t #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic btn,
    output logic T,
    output logic estavel
);

    import debouncer_pkg::*;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 255) begin : g_param_check
        $error("debouncer_pulso_t: DEBOUNCE_CYCLES and REPEAT_CYCLES must be in 2..255");
    end

    // Wide enough to hold DEBOUNCE_CYCLES itself, so the counter never wraps.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

    logic             w_btn_s;
    estado_t          r_estado;
    estado_t          w_prox_estado;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_prox_cnt;
    logic             r_t;
    logic             w_t;
    logic             w_rep_pulse;

    sincronizador_2ff u_sinc (
        .clk   (clk),
        .clear (clear),
        .d     (btn),
        .q     (w_btn_s)
    );

    // State register: FSM state, filter counter and the registered T pulse.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_estado <= SOLTO;
            r_cnt    <= '0;
            r_t      <= 1'b0;
        end else begin
            r_estado <= w_prox_estado;
            r_cnt    <= w_prox_cnt;
            r_t      <= w_t;
        end
    end

    // Next-state logic. The counter holds the number of consecutive samples
    // at the new level; the state change is taken on the edge after it has
    // reached DEBOUNCE_CYCLES, which is why that edge ignores btn_s.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        w_prox_estado = r_estado;
        w_prox_cnt    = r_cnt;
        case (r_estado)
            SOLTO: begin
                if (w_btn_s) begin
                    w_prox_estado = FILTRA_ALTO;
                    w_prox_cnt    = CNT_UM;
                end else begin
                    w_prox_cnt    = '0;
                end
            end
            FILTRA_ALTO: begin
                if (r_cnt == CNT_MAX) begin
                    w_prox_estado = PRESSIONADO;
                    w_prox_cnt    = '0;
                end else if (w_btn_s) begin
                    w_prox_cnt    = r_cnt + CNT_UM;
                end else begin
                    w_prox_estado = SOLTO;
                    w_prox_cnt    = '0;
                end
            end
            PRESSIONADO: begin
                if (!w_btn_s) begin
                    w_prox_estado = FILTRA_BAIXO;
                    w_prox_cnt    = CNT_UM;
                end else begin
                    w_prox_cnt    = '0;
                end
            end
            FILTRA_BAIXO: begin
                if (r_cnt == CNT_MAX) begin
                    w_prox_estado = SOLTO;
                    w_prox_cnt    = '0;
                end else if (!w_btn_s) begin
                    w_prox_cnt    = r_cnt + CNT_UM;
                end else begin
                    w_prox_estado = PRESSIONADO;
                    w_prox_cnt    = '0;
                end
            end
            default: begin
                w_prox_estado = SOLTO;
                w_prox_cnt    = '0;
            end
        endcase
    end

    // Output logic: T is computed from the transition and registered above,
    // so it appears in the first cycle spent in PRESSIONADO.
    always_comb begin
        w_t     = ((r_estado == FILTRA_ALTO) && (w_prox_estado == PRESSIONADO))
                  || w_rep_pulse;
        estavel = (r_estado == PRESSIONADO) || (r_estado == FILTRA_BAIXO);
    end

    assign T = r_t;

`ifdef DEBOUNCER_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_UM  = REP_W'(1);

    logic [REP_W-1:0] r_rep;
    logic             w_rep_hold;

    // Counts only while the button stays accepted; any exit or re-entry
    // restarts the period.
    assign w_rep_hold  = (r_estado == PRESSIONADO) && (w_prox_estado == PRESSIONADO);
    assign w_rep_pulse = w_rep_hold && (r_rep == REP_MAX);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_rep <= '0;
        end else if (!w_rep_hold || w_rep_pulse) begin
            r_rep <= '0;
        end else begin
            r_rep <= r_rep + REP_UM;
        end
    end
`else
    assign w_rep_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer_pulso_t.sv
// -----------------------------------------------------------------------------
// tb_debouncer_pulso_t
// Self-checking bench for debouncer_pulso_t (DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=8, 20 ns clock). A run-length reference model predicts T and
// estavel every cycle; scenario tasks add latency and pulse-count checks.
// -----------------------------------------------------------------------------
module tb_debouncer_pulso_t;

    localparam int D = 4;
    localparam int R = 8;

    logic clk = 1'b0;
    logic clear;
    logic btn;
    logic T;
    logic estavel;

    int checks = 0;
    int errors = 0;

    // Reference model: two-sample input delay, accepted level, run length of
    // samples disagreeing with it, and cycles held since acceptance.
    logic m_b1, m_b2, m_lvl, m_pending, m_t;
    int   m_run, m_rep;
    logic prev_t;
    logic [3:0] q_cnt;

    always #10 clk = ~clk;

    debouncer_pulso_t #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .btn     (btn),
        .T       (T),
        .estavel (estavel)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog time=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_lvl = 0; m_pending = 0; m_t = 0;
        m_run = 0; m_rep = 0;
    endtask

    task automatic model_step(input logic b, input logic clr);
        logic s;
        if (clr) begin
            model_reset();
        end else begin
            s    = m_b2;
            m_b2 = m_b1;
            m_b1 = b;
            m_t  = 0;
            if (m_pending) begin
                m_lvl     = ~m_lvl;
                m_pending = 0;
                m_run     = 0;
                m_rep     = 0;
                if (m_lvl) m_t = 1;
            end else if (s != m_lvl) begin
                m_run++;
                m_rep = 0;
                if (m_run == D) m_pending = 1;
            end else if (m_run > 0) begin
                m_run = 0;
                m_rep = 0;
            end else if (m_lvl) begin
                m_rep++;
                if (m_rep == R) begin
                    m_rep = 0;
`ifdef DEBOUNCER_AUTO_REPEAT_EN
                    m_t = 1;
`endif
                end
            end
        end
    endtask

    // One clock: drive btn, step model on the edge, compare 1 ns later.
    task automatic cycle(input logic b);
        btn = b;
        @(posedge clk);
        model_step(b, clear);
        #1;
        checks++;
        if (T !== m_t) begin
            errors++;
            $display("FAIL t_pulse time=%0t got %b expected %b", $time, T, m_t);
        end
        checks++;
        if (estavel !== m_lvl) begin
            errors++;
            $display("FAIL estavel time=%0t got %b expected %b", $time, estavel, m_lvl);
        end
        checks++;
        if (prev_t === 1'b1 && T === 1'b1) begin
            errors++;
            $display("FAIL t_consecutive time=%0t got 11 expected not both high", $time);
        end
        prev_t = T;
        if (T === 1'b1) q_cnt = q_cnt + 4'd1;
    endtask

    task automatic settle_low(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic test_reset();
        int lat;
        clear = 1'b1; btn = 1'b0; prev_t = 1'b0; q_cnt = '0;
        model_reset();
        cycle(1'b0);
        cycle(1'b0);
        clear = 1'b0;
        for (int i = 0; i < 12; i++) cycle(1'b1);
        // Assert clear mid-cycle while pressed: outputs must drop at once.
        clear = 1'b1;
        model_reset();
        #1;
        checks++;
        if (estavel !== 1'b0 || T !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got estavel=%b T=%b expected 0 0", estavel, T);
        end
        cycle(1'b1);
        clear = 1'b0;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1);
            if (T === 1'b1 && lat < 0) lat = i;
        end
        checks++;
        if (lat !== D + 2) begin
            errors++;
            $display("FAIL reset_latency got %0d expected %0d", lat, D + 2);
        end
        settle_low(14);
    endtask

    task automatic test_clean_press();
        int lat, n, rel;
        lat = -1; n = 0; rel = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (T === 1'b1) begin n++; if (lat < 0) lat = i; end
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL clean_count got %0d expected 1", n);
        end
        checks++;
        if (lat !== D + 2) begin
            errors++;
            $display("FAIL clean_latency got %0d expected %0d", lat, D + 2);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0);
            if (estavel === 1'b0 && rel < 0) rel = i;
        end
        checks++;
        if (rel !== D + 2) begin
            errors++;
            $display("FAIL release_latency got %0d expected %0d", rel, D + 2);
        end
    endtask

    task automatic test_bounce();
        int lat, n;
        lat = -1; n = 0;
        cycle(1'b1); cycle(1'b0); cycle(1'b1); cycle(1'b0);
        checks++;
        if (q_cnt !== q_cnt || T !== 1'b0) begin
            errors++;
            $display("FAIL bounce_early got T=%b expected 0", T);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (T === 1'b1) begin n++; if (lat < 0) lat = i; end
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL bounce_count got %0d expected 1", n);
        end
        checks++;
        if (lat !== D + 2) begin
            errors++;
            $display("FAIL bounce_latency got %0d expected %0d", lat, D + 2);
        end
        settle_low(12);
    endtask

    task automatic test_glitch();
        int n, hi;
        n = 0; hi = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(i < D - 1 ? 1'b1 : 1'b0);
            if (T === 1'b1) n++;
            if (estavel === 1'b1) hi++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL glitch_pulse got %0d expected 0", n);
        end
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL glitch_estavel got %0d high cycles expected 0", hi);
        end
    endtask

    task automatic test_counter();
        q_cnt = '0;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 8; i++) cycle(1'b1);
            settle_low(10);
        end
        checks++;
        if (q_cnt !== 4'd5) begin
            errors++;
            $display("FAIL counter_presses got %0d expected 5", q_cnt);
        end
        // Press interrupted by clear while still filtering.
        for (int i = 0; i < 4; i++) cycle(1'b1);
        clear = 1'b1;
        model_reset();
        cycle(1'b0);
        clear = 1'b0;
        settle_low(12);
        checks++;
        if (q_cnt !== 4'd5) begin
            errors++;
            $display("FAIL counter_clear got %0d expected 5", q_cnt);
        end
    endtask

    task automatic test_hold();
        int n, exp_n;
        n = 0;
`ifdef DEBOUNCER_AUTO_REPEAT_EN
        exp_n = 0;
        for (int p = D + 2; p < 40; p += R) exp_n++;
`else
        exp_n = 1;
`endif
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1);
            if (T === 1'b1) n++;
        end
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL hold_count got %0d expected %0d", n, exp_n);
        end
        settle_low(12);
    endtask

    task automatic test_random();
        logic lvl;
        int   len;
        lvl = 1'b0;
        for (int k = 0; k < 150; k++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 29) == 0) begin
                clear = 1'b1;
                model_reset();
                cycle(lvl);
                clear = 1'b0;
            end
            for (int i = 0; i < len; i++) cycle(lvl);
        end
        settle_low(12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_counter();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer_pulso_t.md
DEBOUNCER_PULSO_T -- requirements
Module: debouncer_pulso_t

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized samples required to accept a level change (legal range 2..255).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 8, meaning held-button repeat period in clk cycles (used only with AUTO_REPEAT_EN; legal range 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clear, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port btn, input, 1 bit: raw asynchronous push-button level, 1 = pressed.
REQ-006 The block SHALL have port T, output, 1 bit: one-cycle count-enable pulse for the downstream 4-bit synchronous counter's T input.
REQ-007 The block SHALL have port estavel, output, 1 bit: debounced button level.

Function
REQ-008 btn SHALL pass through a 2-flop synchronizer; all other logic SHALL use only the synchronized value btn_s.
REQ-009 The FSM SHALL have states SOLTO, FILTRA_ALTO, PRESSIONADO, FILTRA_BAIXO.
REQ-010 SOLTO: btn_s=1 -> FILTRA_ALTO with filter counter loaded to 1; else stay.
REQ-011 FILTRA_ALTO: btn_s=1 increments the counter; on reaching DEBOUNCE_CYCLES -> PRESSIONADO; btn_s=0 -> SOLTO and counter cleared, no pulse.
REQ-012 PRESSIONADO: btn_s=0 -> FILTRA_BAIXO with counter loaded to 1; else stay.
REQ-013 FILTRA_BAIXO: btn_s=0 increments; on reaching DEBOUNCE_CYCLES -> SOLTO; btn_s=1 -> PRESSIONADO, counter cleared, no pulse.
REQ-014 T SHALL be registered and high for exactly the one cycle following the FILTRA_ALTO -> PRESSIONADO transition.
REQ-015 Latency: btn stable high from before edge k SHALL give T=1 during the cycle after edge k+2+DEBOUNCE_CYCLES; release detection SHALL have the same latency.
REQ-016 estavel SHALL be 1 in PRESSIONADO and FILTRA_BAIXO, 0 otherwise.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no T pulse and no estavel change.
REQ-018 The filter counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide and never wrap.
REQ-019 T SHALL never be high in two consecutive cycles.

Reset
REQ-020 clear=1 SHALL immediately force state SOLTO, counters 0, both synchronizer flops 0, T=0, estavel=0, independent of clk.
REQ-021 clear asserted mid-filter or while pressed SHALL discard progress; after release a button still held SHALL require the full REQ-015 latency before T.
REQ-022 Deassertion of clear SHALL take effect at the next rising clk edge.

Configuration
REQ-023 With macro DEBOUNCER_AUTO_REPEAT_EN defined, a REPEAT_CYCLES-wide repeat counter SHALL run in PRESSIONADO and emit an additional one-cycle T pulse every REPEAT_CYCLES cycles after the initial pulse while held; it SHALL clear on leaving PRESSIONADO.
REQ-024 Without DEBOUNCER_AUTO_REPEAT_EN, the repeat counter SHALL not exist and exactly one T pulse SHALL occur per accepted press.

Structure
REQ-025 State encoding (2-bit localparams SOLTO=0, FILTRA_ALTO=1, PRESSIONADO=2, FILTRA_BAIXO=3) SHALL live in shared package/include debouncer_pkg.
REQ-026 The synchronizer SHALL be a separate sub-module sincronizador_2ff (ports clk, clear, d, q).
REQ-027 The block SHALL contain one FSM, one filter counter, and the optional repeat counter; no combinational path SHALL run from btn to T.

Verification (clk period 20 ns, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-028 clear=1 for 20 ns with btn=1 -> T=0, estavel=0 throughout; after clear=0, the first T pulse occurs 6 cycles later.
REQ-029 Clean press: btn 0->1 held 200 ns -> exactly one 20 ns T pulse, 6 cycles after the first sampling edge; estavel=1 from the same cycle.
REQ-030 Bounce: btn toggles 1,0,1,0 every 20 ns then holds 1 -> a single T pulse, timed from the start of the stable hold.
REQ-031 Glitch: btn=1 for 3 cycles then 0 -> T never pulses; estavel stays 0; state returns to SOLTO.
REQ-032 With downstream counter: 5 clean presses -> counter q goes 0->5; clear mid-press (pulse during FILTRA_ALTO) -> no pulse for that press.
REQ-033 With DEBOUNCER_AUTO_REPEAT_EN: btn held 40 cycles -> pulses at cycle 6, then every 8 cycles (14, 22, 30, 38); without the macro -> one pulse only.
